// File: rtl/vfifo_sync_fifo_ctrl.sv
// Single-clock FIFO controller in front of a dual-port RAM.
// Port A writes. Port B reads, and its data returns one cycle after the address is issued.
// A 2-entry output buffer (OB) gives a first-word-fall-through read port.
// The OB hides the RAM read latency, so the FIFO sustains one word per cycle.
//
// Handshake: a word moves on the read port on a rising edge where rd_valid && rd_ready.
// rd_valid never depends combinationally on rd_ready.
// While rd_valid && !rd_ready, rd_data holds stable.
// On the write side a word is taken on a rising edge where wr_en && !full.
// A write offered while full is dropped and reported by a one-cycle overflow pulse.
module vfifo_sync_fifo_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 9,
    parameter int AFULL_LVL  = (2**ADDR_WIDTH)-4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  full,
    output logic                  almost_full,
    output logic                  overflow,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [ADDR_WIDTH+1:0] fill_count,
    output logic [ADDR_WIDTH-1:0] ram_adr_a,
    output logic [DATA_WIDTH-1:0] ram_d_a,
    output logic                  ram_we_a,
    output logic [ADDR_WIDTH-1:0] ram_adr_b,
    output logic                  ram_we_b,
    output logic [DATA_WIDTH-1:0] ram_d_b,
    input  logic [DATA_WIDTH-1:0] ram_q_b
);

    localparam logic [ADDR_WIDTH:0] DEPTH_C = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] AFULL_C = (ADDR_WIDTH+1)'(AFULL_LVL);

    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH:0]   ram_count;
    logic [ADDR_WIDTH:0]   ram_count_nxt;
    logic                  inflight;
    logic [1:0]            ob_count;
    logic [1:0]            ob_count_nxt;
    logic [DATA_WIDTH-1:0] ob_head;
    logic [DATA_WIDTH-1:0] ob_tail;
    logic                  rd_valid_q;
    logic                  full_q;
    logic                  afull_q;
    logic                  overflow_q;
    logic                  push;
    logic                  pop;
    logic                  issue;
    logic [2:0]            ob_pending;

    assign push = wr_en & ~full_q;
    assign pop  = rd_valid_q & rd_ready;

    // Words that will occupy the OB after this edge, if nothing new is issued.
    // An issue is allowed only if its returning word is sure to find a free slot.
    // ram_count only covers words written before this edge.
    // So port B never reads the address port A is writing now.
    assign ob_pending = {1'b0, ob_count} + {2'b00, inflight} - {2'b00, pop};
    assign issue      = (ram_count != '0) && (ob_pending < 3'd2);

    assign ram_count_nxt = ram_count + (ADDR_WIDTH+1)'(push) - (ADDR_WIDTH+1)'(issue);
    assign ob_count_nxt  = ob_count + {1'b0, inflight} - {1'b0, pop};

    // RAM pointers, RAM occupancy, read-in-flight flag and the registered status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            ram_count  <= '0;
            inflight   <= 1'b0;
            full_q     <= 1'b0;
            afull_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (issue) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            ram_count  <= ram_count_nxt;
            inflight   <= issue;
            full_q     <= (ram_count_nxt == DEPTH_C);
            afull_q    <= (ram_count_nxt >= AFULL_C);
            overflow_q <= wr_en & full_q;
        end
    end

    // Output buffer: ob_head is the word on rd_data, and ob_tail is the second entry.
    // A returning RAM word goes to the first free slot left after this edge's pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            ob_count   <= 2'd0;
            ob_head    <= '0;
            ob_tail    <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            ob_count   <= ob_count_nxt;
            rd_valid_q <= (ob_count_nxt != 2'd0);
            case ({pop, inflight})
                2'b10: begin
                    if (ob_count == 2'd2) begin
                        ob_head <= ob_tail;
                    end
                end
                2'b01: begin
                    if (ob_count == 2'd0) begin
                        ob_head <= ram_q_b;
                    end else begin
                        ob_tail <= ram_q_b;
                    end
                end
                2'b11: begin
                    if (ob_count == 2'd1) begin
                        ob_head <= ram_q_b;
                    end else begin
                        ob_head <= ob_tail;
                        ob_tail <= ram_q_b;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign full        = full_q;
    assign almost_full = afull_q;
    assign overflow    = overflow_q;
    assign rd_data     = ob_head;
    assign rd_valid    = rd_valid_q;
    assign fill_count  = (ADDR_WIDTH+2)'(ram_count) + (ADDR_WIDTH+2)'(inflight)
                       + (ADDR_WIDTH+2)'(ob_count);

    assign ram_adr_a = wr_ptr;
    assign ram_d_a   = wr_data;
    assign ram_we_a  = push;
    assign ram_adr_b = rd_ptr;
    assign ram_we_b  = 1'b0;
    assign ram_d_b   = '0;

endmodule

// File: tb/tb_vfifo_sync_fifo_ctrl.sv
// Bench for vfifo_sync_fifo_ctrl with a 4-deep RAM model on its RAM ports.
// Writes expected to be accepted are queued as they are driven.
// An independent monitor pops and compares on every read handshake.
module tb_vfifo_sync_fifo_ctrl;

    localparam int DW = 8;
    localparam int AW = 2;

    logic          clk;
    logic          rst;
    logic          wr_en;
    logic [DW-1:0] wr_data;
    logic          full;
    logic          almost_full;
    logic          overflow;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          rd_ready;
    logic [AW+1:0] fill_count;
    logic [AW-1:0] ram_adr_a;
    logic [DW-1:0] ram_d_a;
    logic          ram_we_a;
    logic [AW-1:0] ram_adr_b;
    logic          ram_we_b;
    logic [DW-1:0] ram_d_b;
    logic [DW-1:0] ram_q_b;

    logic [DW-1:0] exp_q[$];
    int            n_checks = 0;
    int            n_pass   = 0;

    vfifo_sync_fifo_ctrl #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .AFULL_LVL (3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .full       (full),
        .almost_full(almost_full),
        .overflow   (overflow),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .rd_ready   (rd_ready),
        .fill_count (fill_count),
        .ram_adr_a  (ram_adr_a),
        .ram_d_a    (ram_d_a),
        .ram_we_a   (ram_we_a),
        .ram_adr_b  (ram_adr_b),
        .ram_we_b   (ram_we_b),
        .ram_d_b    (ram_d_b),
        .ram_q_b    (ram_q_b)
    );

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // RAM model: synchronous write on port A, registered read on port B
    logic [DW-1:0] ram_mem [4];
    always @(posedge clk) begin
        if (ram_we_a) ram_mem[ram_adr_a] <= ram_d_a;
        ram_q_b <= ram_mem[ram_adr_b];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Drive one cycle's inputs and return at the following negedge for sampling
    task automatic drive(input logic we, input logic [DW-1:0] d, input logic rr,
                         input logic expect_acc);
        wr_en    = we;
        wr_data  = d;
        rd_ready = rr;
        if (we && expect_acc) exp_q.push_back(d);
        @(negedge clk);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Scoreboard monitor: each read handshake must match the oldest expected word
    always @(negedge clk) begin
        if (!rst && rd_valid && rd_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL rd_unexpected: got 0x%0h expected no word at %0t", rd_data, $time);
            end else begin
                check("rd_data", rd_data, exp_q.pop_front());
            end
        end
    end

    initial begin
        rst      = 1'b1;
        wr_en    = 1'b0;
        wr_data  = '0;
        rd_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_full", full, 0);
        check("rst_almost_full", almost_full, 0);
        check("rst_overflow", overflow, 0);
        check("rst_fill_count", fill_count, 0);
        check("rst_rd_data", rd_data, 0);
        check("ram_we_b", ram_we_b, 0);
        check("ram_d_b", ram_d_b, 0);
        tick();
        rst = 1'b0;

        // Idle after reset
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 8'h00, 1'b0, 1'b0);
            check("idle_rd_valid", rd_valid, 0);
            check("idle_full", full, 0);
            check("idle_fill_count", fill_count, 0);
            check("idle_ram_we_a", ram_we_a, 0);
            tick();
        end

        // Single word: latency through RAM and OB
        drive(1'b1, 8'h11, 1'b1, 1'b1);
        check("t1_ram_we_a", ram_we_a, 1);
        check("t1_ram_adr_a", ram_adr_a, 0);
        tick();
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        check("t1_c1_fill", fill_count, 1);
        check("t1_c1_rd_valid", rd_valid, 0);
        tick();
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        check("t1_c2_fill", fill_count, 1);
        check("t1_c2_rd_valid", rd_valid, 0);
        tick();
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        check("t1_c3_rd_valid", rd_valid, 1);
        check("t1_c3_rd_data", rd_data, 8'h11);
        check("t1_c3_fill", fill_count, 1);
        tick();
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        check("t1_c4_rd_valid", rd_valid, 0);
        check("t1_c4_fill", fill_count, 0);
        tick();

        // Fill to capacity with no reader; the 7th write overflows
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, 8'(i + 1), 1'b0, i < 6);
            if (i == 4) check("t2_afull_lo", almost_full, 0);
            if (i == 5) begin
                check("t2_afull_hi", almost_full, 1);
                check("t2_full_lo", full, 0);
                check("t2_fill5", fill_count, 5);
            end
            if (i == 6) begin
                check("t2_full_hi", full, 1);
                check("t2_fill6", fill_count, 6);
                check("t2_we_blocked", ram_we_a, 0);
                check("t2_ovf_pre", overflow, 0);
            end
            tick();
        end
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        check("t2_ovf_pulse", overflow, 1);
        check("t2_fill_hold", fill_count, 6);
        check("t2_full_hold", full, 1);
        tick();
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        check("t2_ovf_end", overflow, 0);
        tick();

        // Drain at full rate: six words on consecutive cycles
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, 8'h00, 1'b1, 1'b0);
            check("t3_rd_valid", rd_valid, 1);
            if (i == 0) check("t3_full_before", full, 1);
            if (i == 1) check("t3_full_after", full, 0);
            tick();
        end
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        check("t3_rd_valid_end", rd_valid, 0);
        check("t3_fill_end", fill_count, 0);
        check("t3_queue_empty", exp_q.size(), 0);
        tick();

        // Streaming: push and pop every cycle through several pointer wraps
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 8'(8'h20 + i), 1'b1, 1'b1);
            if (i >= 3) check("t4_fill_const", fill_count, 3);
            tick();
        end
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 8'h00, 1'b1, 1'b0);
            tick();
        end
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        check("t4_fill_end", fill_count, 0);
        check("t4_queue_empty", exp_q.size(), 0);
        tick();

        // Reset with 3 words held and one read in flight
        drive(1'b1, 8'h51, 1'b0, 1'b1);
        tick();
        drive(1'b1, 8'h52, 1'b0, 1'b1);
        tick();
        drive(1'b1, 8'h53, 1'b0, 1'b1);
        tick();
        rst = 1'b1;
        exp_q.delete();
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        check("t5_fill_pre", fill_count, 3);
        check("t5_rd_valid_pre", rd_valid, 1);
        tick();
        rst = 1'b0;
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        check("t5_rd_valid_post", rd_valid, 0);
        check("t5_fill_post", fill_count, 0);
        tick();
        drive(1'b1, 8'hAA, 1'b1, 1'b1);
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 8'h00, 1'b1, 1'b0);
            tick();
        end
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        check("t5_fill_end", fill_count, 0);
        check("t5_queue_empty", exp_q.size(), 0);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
